command_issuer: RTL and testbench

- UART-side initiator that issues one-byte commands to the acoustics command reader and collects its reply.
- Takes a request (opcode nibble plus argument nibble), drives the UART transmitter byte interface, and waits on the UART receiver byte interface for the reply where one is expected.
- Returns the reply byte or a timeout flag.
- Used on the host-emulation/self-test FPGA path and by boards that command the acoustics board over the serial link.

---
 rtl/command_issuer.sv | 96 +++++++++
 tb/tb_command_issuer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/command_issuer.sv
// command_issuer: sends one opcode/argument byte to the UART transmitter and
// collects the optional reply byte from the receiver, flagging a timeout if none arrives.
module command_issuer #(
    parameter int unsigned RSP_TIMEOUT  = 100000000,
    parameter int unsigned TRIG_TIMEOUT = 1000000000,
    parameter int          CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_opcode,
    input  logic [3:0] req_arg,
    output logic [7:0] tx_data,
    output logic       tx_write_en,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       rx_stray,
    output logic       busy,
    output logic [2:0] state_debug
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_RSP = 3'd2,
        DONE     = 3'd3,
        DONE_TO  = 3'd4
    } state_t;

    state_t           r_state, w_next;
    logic [7:0]       r_tx_data, r_rsp_data;
    logic             r_expects, r_rx_stray;
    logic [CNT_W-1:0] r_cnt, r_limit;
    logic             w_accept, w_timeout;

    assign w_accept  = req_valid && r_state == IDLE;
    assign w_timeout = r_cnt == r_limit - CNT_W'(1);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (req_valid) w_next = SEND;
            SEND:     if (tx_ready) w_next = r_expects ? WAIT_RSP : DONE;
            WAIT_RSP: w_next = rx_ready ? DONE : (w_timeout ? DONE_TO : WAIT_RSP);
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_tx_data  <= 8'h00;
            r_rsp_data <= 8'h00;
            r_expects  <= 1'b0;
            r_rx_stray <= 1'b0;
            r_cnt      <= '0;
            r_limit    <= '0;
        end else begin
            r_rx_stray <= rx_ready && r_state != WAIT_RSP;
            if (w_accept) begin
                r_tx_data <= {req_opcode, req_arg};
                r_expects <= req_opcode == 4'h4 || req_opcode == 4'hd;
                r_limit   <= req_opcode == 4'hd ? CNT_W'(TRIG_TIMEOUT) : CNT_W'(RSP_TIMEOUT);
            end
            if (r_state == SEND)
                r_cnt <= '0;
            else if (r_state == WAIT_RSP)
                r_cnt <= r_cnt + CNT_W'(1);
            // Fire-and-forget and timed-out completions report an empty reply.
            if (r_state == SEND && tx_ready && !r_expects)
                r_rsp_data <= 8'h00;
            else if (r_state == WAIT_RSP)
                r_rsp_data <= rx_ready ? rx_data : (w_timeout ? 8'h00 : r_rsp_data);
        end
    end

    assign req_ready   = r_state == IDLE;
    assign busy        = r_state != IDLE;
    assign tx_data     = r_tx_data;
    assign tx_write_en = r_state == SEND;
    assign rsp_valid   = r_state == DONE || r_state == DONE_TO;
    assign rsp_timeout = r_state == DONE_TO;
    assign rsp_data    = r_rsp_data;
    assign rx_stray    = r_rx_stray;
    assign state_debug = r_state;
endmodule

// File: tb/tb_command_issuer.sv
// tb_command_issuer: directed and randomized command transactions checked
// against a cycle-count model of request, transmit, reply and timeout rules.
module tb_command_issuer;
    localparam int RSP_TO  = 16;
    localparam int TRIG_TO = 40;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_opcode = 4'h0;
    logic [3:0] req_arg = 4'h0;
    logic [7:0] tx_data;
    logic       tx_write_en;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       rx_stray;
    logic       busy;
    logic [2:0] state_debug;

    int n_cmp = 0;
    int n_err = 0;

    command_issuer #(.RSP_TIMEOUT(RSP_TO), .TRIG_TIMEOUT(TRIG_TO), .CNT_W(32)) dut (
        .clk(clk), .reset_b(reset_b),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_arg(req_arg),
        .tx_data(tx_data), .tx_write_en(tx_write_en), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .rx_stray(rx_stray), .busy(busy), .state_debug(state_debug)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // d = cycles after the write cycle at which a reply pulse arrives (0 = never)
    task automatic run(input logic [3:0] op, input logic [3:0] arg, input int txd,
                       input int d, input logic [7:0] rep, input bit stray);
        int lim, ek, k;
        logic [7:0] ed;
        logic eto;
        lim = (op == 4'h4) ? RSP_TO : (op == 4'hd) ? TRIG_TO : 0;
        if (lim == 0) begin
            ek = 1; ed = 8'h00; eto = 1'b0;
        end else if (d >= 1 && d <= lim) begin
            ek = d + 1; ed = rep; eto = 1'b0;
        end else begin
            ek = lim + 1; ed = 8'h00; eto = 1'b1;
        end
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_opcode = op; req_arg = arg;
        tick;
        req_valid = 1'b0; req_opcode = 4'($urandom); req_arg = 4'($urandom);
        for (int j = 0; j < txd; j++) begin
            chk("tx_we_bp", 32'(tx_write_en), 1);
            chk("tx_data_bp", 32'(tx_data), 32'({op, arg}));
            chk("no_rsp_bp", 32'(rsp_valid), 0);
            if (stray && j == 1) begin
                chk("stray_send", 32'(rx_stray), 1);
                chk("state_send", 32'(state_debug), 1);
            end
            rx_ready = stray && j == 0; rx_data = 8'h11;
            tick;
            rx_ready = 1'b0;
        end
        chk("tx_we", 32'(tx_write_en), 1);
        chk("tx_data", 32'(tx_data), 32'({op, arg}));
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        k = 0;
        for (int c = 1; c <= 60 && k == 0; c++) begin
            if (rsp_valid) k = c;
            else begin
                rx_ready = (c == d);
                rx_data = (c == d) ? rep : 8'($urandom);
                tick;
                rx_ready = 1'b0;
            end
        end
        chk("tx_we_off", 32'(tx_write_en), 0);
        chk("rsp_cycle", k, ek);
        chk("rsp_timeout", 32'(rsp_timeout), 32'(eto));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        tick;
        chk("rsp_valid_pulse", 32'(rsp_valid), 0);
        chk("req_ready_after", 32'(req_ready), 1);
        chk("busy_after", 32'(busy), 0);
        chk("rsp_data_hold", 32'(rsp_data), 32'(ed));
    endtask

    initial begin
        logic [3:0] op;
        int d;
        #1;
        chk("rst_state", 32'(state_debug), 0);
        chk("rst_tx_we", 32'(tx_write_en), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_to", 32'(rsp_timeout), 0);
        chk("rst_stray", 32'(rx_stray), 0);
        tick; tick;
        reset_b = 1'b1;
        tick;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);

        run(4'hf, 4'h3, 0, 0, 8'h00, 1'b0);
        run(4'h7, 4'ha, 5, 0, 8'h00, 1'b0);
        run(4'h4, 4'h0, 0, 10, 8'h5c, 1'b0);
        run(4'hd, 4'h5, 1, 20, 8'hc3, 1'b0);
        run(4'h4, 4'h0, 0, 0, 8'h00, 1'b0);
        run(4'h4, 4'h1, 0, 16, 8'ha5, 1'b0);
        run(4'h4, 4'h2, 2, 17, 8'h99, 1'b0);
        run(4'hd, 4'h0, 0, 40, 8'h77, 1'b0);

        rx_ready = 1'b1; rx_data = 8'h11;
        tick;
        rx_ready = 1'b0;
        chk("stray_idle", 32'(rx_stray), 1);
        chk("state_idle", 32'(state_debug), 0);
        tick;
        chk("stray_idle_pulse", 32'(rx_stray), 0);
        run(4'hd, 4'h2, 3, 5, 8'h01, 1'b1);

        req_valid = 1'b1; req_opcode = 4'h4; req_arg = 4'h0;
        tick;
        req_valid = 1'b0; tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        tick; tick; tick;
        chk("mid_wait_state", 32'(state_debug), 2);
        reset_b = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_debug), 0);
        chk("mid_rst_tx_we", 32'(tx_write_en), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 0);
        tick;
        reset_b = 1'b1;
        rx_ready = 1'b1; rx_data = 8'h42;
        tick;
        rx_ready = 1'b0;
        chk("late_rx_stray", 32'(rx_stray), 1);
        for (int i = 0; i < RSP_TO + 3; i++) begin
            chk("late_no_rsp", 32'(rsp_valid | tx_write_en), 0);
            tick;
        end
        chk("late_rsp_data", 32'(rsp_data), 0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: op = 4'h4;
                1: op = 4'hd;
                2: op = 4'hf;
                default: op = 4'($urandom);
            endcase
            d = (op == 4'h4 || op == 4'hd) ? int'($urandom_range(0, TRIG_TO + 3)) : 0;
            run(op, 4'($urandom), int'($urandom_range(0, 3)), d, 8'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
